// File: rtl/ucsbece154a_mem_waitstate.sv
// ucsbece154a_mem_waitstate: unified word RAM with LATENCY wait states and a req/ready handshake.
// Optional MEM_BYTE_STROBE_EN: writes update only the bytes selected by be_i.
module ucsbece154a_mem_waitstate #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        misalign_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, misalign_q;
  logic        idle, accept, enter_resp, misalign, acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_be;
  logic [AW-1:0] idx;
  logic        unused_ok;
  logic [31:0] mem [DEPTH_WORDS];
  // With LATENCY==1 the access completes on the accepting edge, so live inputs are used then.
  always_comb begin
    idle       = state_q == IDLE;
    accept     = idle && req_i;
    acc_we     = idle ? we_i    : we_q;
    acc_addr   = idle ? addr_i  : addr_q;
    acc_wdata  = idle ? wdata_i : wdata_q;
    acc_be     = idle ? be_i    : be_q;
    misalign   = |acc_addr[1:0];
    idx        = acc_addr[AW+1:2];
    enter_resp = idle ? (req_i && (LATENCY == 1)) : (state_q == WAIT && count_q == 4'd1);
    state_d    = enter_resp ? RESP : accept ? WAIT : (state_q == RESP) ? IDLE : state_q;
    count_d    = accept ? 4'(LATENCY - 1) : (state_q == WAIT) ? count_q - 4'd1 : count_q;
    rdata_d    = !enter_resp ? rdata_q : misalign ? 32'd0 : acc_we ? rdata_q : mem[idx];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      rdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      ready_q    <= enter_resp;
      misalign_q <= enter_resp && misalign;
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        be_q    <= be_i;
      end
    end
  end
`ifdef MEM_BYTE_STROBE_EN
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !misalign)
      for (int b = 0; b < 4; b++)
        if (acc_be[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
  end
  assign unused_ok = ^{acc_addr[31:AW+2]};
`else
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !misalign) mem[idx] <= acc_wdata;
  end
  assign unused_ok = ^{acc_addr[31:AW+2], acc_be};
`endif
  assign rdata_o    = rdata_q;
  assign ready_o    = ready_q;
  assign misalign_o = misalign_q;
  assign busy_o     = state_q != IDLE;
endmodule

// File: tb/tb_ucsbece154a_mem_waitstate.sv
// tb_ucsbece154a_mem_waitstate: scoreboard bench driving a LATENCY=1 and a LATENCY=2 instance.
module tb_ucsbece154a_mem_waitstate;
  typedef struct {int cyc; logic mis; logic chk; logic [31:0] rd;} exp_t;
  logic clk = 0, reset = 1, req1 = 0, req2 = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] be = 4'hF;
  logic [31:0] rdata1, rdata2;
  logic ready1, ready2, busy1, busy2, mis1, mis2;
  int cyc = 0, checks = 0, fails = 0;
  exp_t q1[$], q2[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ucsbece154a_mem_waitstate #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_i(req1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .be_i(be), .rdata_o(rdata1), .ready_o(ready1), .busy_o(busy1), .misalign_o(mis1));
  ucsbece154a_mem_waitstate #(.DEPTH_WORDS(256), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .req_i(req2), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .be_i(be), .rdata_o(rdata2), .ready_o(ready2), .busy_o(busy2), .misalign_o(mis2));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic resp(input string tag, input exp_t e, input logic mis, input logic [31:0] rd);
    chk({tag, " latency"}, cyc, e.cyc);
    chk({tag, " misalign"}, {31'd0, mis}, {31'd0, e.mis});
    if (e.chk) chk({tag, " rdata"}, rd, e.rd);
  endtask
  always @(negedge clk) begin
    if (!reset && ready1) begin
      if (q1.size() == 0) chk("lat1 unexpected ready", 1, 0);
      else resp("lat1", q1.pop_front(), mis1, rdata1);
    end
  end
  always @(negedge clk) begin
    if (!reset && ready2) begin
      if (q2.size() == 0) chk("lat2 unexpected ready", 1, 0);
      else resp("lat2", q2.pop_front(), mis2, rdata2);
    end
  end
  // Issue one access to both instances, scramble inputs after capture, then wait for both to idle.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] exp);
    int acc, n1, n2;
    logic m;
    m = |a[1:0];
    @(negedge clk);
    req1 = 1; req2 = 1; we = w; addr = a; wdata = d; be = b;
    acc = cyc + 1;
    q1.push_back('{acc, m, !w || m, m ? 32'd0 : exp});
    q2.push_back('{acc + 1, m, !w || m, m ? 32'd0 : exp});
    @(negedge clk);
    req1 = 0; req2 = 0; we = ~w; addr = 32'hFFFF_FFF0; wdata = ~d; be = ~b;
    n1 = 0; n2 = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy1 && !busy2) break;
      n1 += int'(busy1); n2 += int'(busy2);
      @(negedge clk);
    end
    chk("lat1 busy cycles", n1, 1);
    chk("lat2 busy cycles", n2, 2);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset ready", {ready1, ready2}, 0);
    chk("reset busy", {busy1, busy2}, 0);
    chk("reset misalign", {mis1, mis2}, 0);
    chk("reset rdata", rdata1 | rdata2, 0);
    reset = 0;
    access(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    access(0, 32'h10, 0, 4'hF, 32'hDEADBEEF);
    access(1, 32'h4, 32'hCAFEF00D, 4'hF, 0);
    access(0, 32'h4, 0, 4'hF, 32'hCAFEF00D);
    access(0, 32'h6, 0, 4'hF, 0);
    access(1, 32'h5, 32'h0BADBAD0, 4'hF, 0);
    access(0, 32'h4, 0, 4'hF, 32'hCAFEF00D);
    access(1, 32'h400, 32'h12345678, 4'hF, 0);
    access(0, 32'h0, 0, 4'hF, 32'h12345678);
    access(1, 32'h20, 32'h11111111, 4'hF, 0);
    access(0, 32'h10, 0, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    req2 = 1; we = 1; addr = 32'h20; wdata = 32'hAAAAAAAA;
    @(negedge clk);
    req2 = 0;
    chk("pre-reset busy", {31'd0, busy2}, 1);
    reset = 1;
    #1;
    chk("mid-access reset outputs", {ready2, busy2, mis2}, 0);
    chk("mid-access reset rdata", rdata2, 0);
    @(negedge clk);
    reset = 0;
    access(0, 32'h20, 0, 4'hF, 32'h11111111);
    access(1, 32'h30, 32'h11223344, 4'hF, 0);
    access(1, 32'h30, 32'hAABBCCDD, 4'b0101, 0);
`ifdef MEM_BYTE_STROBE_EN
    access(0, 32'h30, 0, 4'hF, 32'h11BB33DD);
`else
    access(0, 32'h30, 0, 4'hF, 32'hAABBCCDD);
`endif
    access(1, 32'h8, 32'h5A5A5A5A, 4'hF, 0);
    @(negedge clk);
    req1 = 1; we = 0; addr = 32'h8;
    q1.push_back('{cyc + 1, 1'b0, 1'b1, 32'h5A5A5A5A});
    q1.push_back('{cyc + 3, 1'b0, 1'b1, 32'h5A5A5A5A});
    repeat (4) @(negedge clk);
    req1 = 0;
    repeat (4) @(negedge clk);
    chk("lat1 pending responses", q1.size(), 0);
    chk("lat2 pending responses", q2.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
